// File: rtl/uart_pkg.sv
// Shared UART RX definitions: status bit positions and frame width helper.
// Used by the datapath, the RX controller and the register block.
package uart_pkg;

  localparam int ST_STOP     = 0;
  localparam int ST_PARITY   = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_BREAK    = 3;

  function automatic int sr_width(input int dw, input int pen);
    return dw + ((pen != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output is defined from reset.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_datapath_receiver.sv
// UART RX datapath: line sync, sample/bit counters, shift register,
// parity check, byte publish and sticky error status.
module uart_datapath_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  inc_sample_count,
  input  logic                  clr_sample_count,
  input  logic                  inc_bit_count,
  input  logic                  clr_bit_count,
  input  logic                  shift,
  input  logic                  load_RX_shift_reg,
  input  logic                  stop_error,
  input  logic                  parity_error,
  input  logic                  break_error,
  input  logic                  overflow_error,
  input  logic                  clr_status,
  output logic                  serial_data_in,
  output logic                  sample_count_done1,
  output logic                  sample_count_done2,
  output logic                  bit_count_done,
  output logic                  RX_shift_reg_2_0,
  output logic                  parity_check,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_done,
  output logic [3:0]            status
);

  localparam int   SR_W = sr_width(DATA_WIDTH, PARITY_EN);
  localparam int   SC_W = $clog2(OVERSAMPLE);
  localparam int   BC_W = $clog2(SR_W + 1);
  localparam logic ODD  = (PARITY_ODD != 0);

  logic [SC_W-1:0] sample_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic [SR_W-1:0] sr;
  logic [3:0]      set_v;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (serial_data_in)
  );

  // Power-of-two OVERSAMPLE: natural wrap at OVERSAMPLE-1
  always_ff @(posedge clk) begin
    if (reset || clr_sample_count)
      sample_cnt <= '0;
    else if (inc_sample_count)
      sample_cnt <= sample_cnt + 1'b1;
  end

  assign sample_count_done1 = (sample_cnt == SC_W'(OVERSAMPLE/2 - 1));
  assign sample_count_done2 = (sample_cnt == SC_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset || clr_bit_count)
      bit_cnt <= '0;
    else if (inc_bit_count && !bit_count_done)
      bit_cnt <= bit_cnt + 1'b1;
  end

  assign bit_count_done = (bit_cnt == BC_W'(SR_W));

  always_ff @(posedge clk) begin
    if (reset)
      sr <= '0;
    else if (shift)
      sr <= {serial_data_in, sr[SR_W-1:1]};
  end

  assign RX_shift_reg_2_0 = |sr;
  assign parity_check     = (PARITY_EN != 0) ? ~(^sr ^ ODD) : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rx_valid   <= load_RX_shift_reg;
      frame_done <= load_RX_shift_reg | stop_error
                  | parity_error | break_error;
      if (load_RX_shift_reg)
        rx_data <= sr[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    set_v              = '0;
    set_v[ST_STOP]     = stop_error;
    set_v[ST_PARITY]   = parity_error;
    set_v[ST_OVERFLOW] = overflow_error;
    set_v[ST_BREAK]    = break_error;
  end

  // A strobe coincident with clr_status keeps its flag set
  always_ff @(posedge clk) begin
    if (reset)
      status <= '0;
    else if (clr_status)
      status <= set_v;
    else
      status <= status | set_v;
  end

endmodule

// File: tb/tb_uart_datapath_receiver.sv
// Self-checking bench for uart_datapath_receiver (8E1 and 7N1 builds).
// The bench acts as the RX controller and models frames arithmetically.
module tb_uart_datapath_receiver;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic inc_sample_count, clr_sample_count;
  logic inc_bit_count, clr_bit_count;
  logic shift, load_RX_shift_reg;
  logic stop_error, parity_error, break_error, overflow_error;
  logic clr_status;

  logic       serial_data_in, sample_count_done1, sample_count_done2;
  logic       bit_count_done, RX_shift_reg_2_0, parity_check;
  logic [7:0] rx_data;
  logic       rx_valid, frame_done;
  logic [3:0] status;

  logic       sdi2, scd1_2, scd2_2, bcd2, sror2, pchk2;
  logic [6:0] rx_data2;
  logic       rx_valid2, frame_done2;
  logic [3:0] status2;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_data;

  always #5 clk = ~clk;

  uart_datapath_receiver #(
    .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .inc_sample_count(inc_sample_count),
    .clr_sample_count(clr_sample_count),
    .inc_bit_count(inc_bit_count), .clr_bit_count(clr_bit_count),
    .shift(shift), .load_RX_shift_reg(load_RX_shift_reg),
    .stop_error(stop_error), .parity_error(parity_error),
    .break_error(break_error), .overflow_error(overflow_error),
    .clr_status(clr_status),
    .serial_data_in(serial_data_in),
    .sample_count_done1(sample_count_done1),
    .sample_count_done2(sample_count_done2),
    .bit_count_done(bit_count_done),
    .RX_shift_reg_2_0(RX_shift_reg_2_0),
    .parity_check(parity_check),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_done(frame_done), .status(status)
  );

  uart_datapath_receiver #(
    .DATA_WIDTH(7), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16)
  ) dut2 (
    .clk(clk), .reset(reset), .rxd(rxd),
    .inc_sample_count(inc_sample_count),
    .clr_sample_count(clr_sample_count),
    .inc_bit_count(inc_bit_count), .clr_bit_count(clr_bit_count),
    .shift(shift), .load_RX_shift_reg(load_RX_shift_reg),
    .stop_error(stop_error), .parity_error(parity_error),
    .break_error(break_error), .overflow_error(overflow_error),
    .clr_status(clr_status),
    .serial_data_in(sdi2),
    .sample_count_done1(scd1_2),
    .sample_count_done2(scd2_2),
    .bit_count_done(bcd2),
    .RX_shift_reg_2_0(sror2),
    .parity_check(pchk2),
    .rx_data(rx_data2), .rx_valid(rx_valid2),
    .frame_done(frame_done2), .status(status2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rxd = 1'b1;
    inc_sample_count = 0; clr_sample_count = 0;
    inc_bit_count = 0; clr_bit_count = 0;
    shift = 0; load_RX_shift_reg = 0;
    stop_error = 0; parity_error = 0;
    break_error = 0; overflow_error = 0;
    clr_status = 0;
  endtask

  // One bit on the line: wait out the synchroniser, then capture it
  task automatic shift_bit(input logic b);
    rxd = b;
    tick();
    tick();
    shift = 1; inc_bit_count = 1;
    tick();
    shift = 0; inc_bit_count = 0;
  endtask

  task automatic send_bits(input logic [8:0] v, input int n);
    clr_bit_count = 1;
    tick();
    clr_bit_count = 0;
    for (int i = 0; i < n; i++) shift_bit(v[i]);
    rxd = 1'b1;
  endtask

  function automatic logic even_bit(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if (serial_data_in !== 1'b1 || sample_count_done1 !== 1'b0 ||
        sample_count_done2 !== 1'b0 || bit_count_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got sdi=%b d1=%b d2=%b bcd=%b, want 1 0 0 0",
               serial_data_in, sample_count_done1,
               sample_count_done2, bit_count_done);
    end
    checks++;
    if (RX_shift_reg_2_0 !== 1'b0 || parity_check !== 1'b1 ||
        pchk2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_sr: got or=%b pchk=%b pchk2=%b, want 0 1 1",
               RX_shift_reg_2_0, parity_check, pchk2);
    end
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 ||
        frame_done !== 1'b0 || status !== 4'h0) begin
      errors++;
      $display("FAIL reset_out: got data=%h v=%b fd=%b st=%b, want 00 0 0 0000",
               rx_data, rx_valid, frame_done, status);
    end
    last_data = 8'h00;
  endtask

  task automatic test_good_frame(input logic [7:0] d);
    logic [8:0] fr;
    fr = {even_bit(d), d};
    send_bits(fr, 9);
    checks++;
    if (bit_count_done !== 1'b1 || parity_check !== 1'b1 ||
        RX_shift_reg_2_0 !== (fr != 0)) begin
      errors++;
      $display("FAIL good_pre(%h): got bcd=%b pchk=%b or=%b, want 1 1 %b",
               d, bit_count_done, parity_check, RX_shift_reg_2_0, fr != 0);
    end
    load_RX_shift_reg = 1;
    tick();
    load_RX_shift_reg = 0;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== d || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL good_load(%h): got v=%b data=%h fd=%b, want 1 %h 1",
               d, rx_valid, rx_data, frame_done, d);
    end
    last_data = d;
    tick();
    checks++;
    if (rx_valid !== 1'b0 || frame_done !== 1'b0 || status !== 4'h0) begin
      errors++;
      $display("FAIL good_post(%h): got v=%b fd=%b st=%b, want 0 0 0000",
               d, rx_valid, frame_done, status);
    end
  endtask

  task automatic test_parity_error(input logic [7:0] d);
    logic [8:0] fr;
    fr = {~even_bit(d), d};
    send_bits(fr, 9);
    checks++;
    if (parity_check !== 1'b0) begin
      errors++;
      $display("FAIL perr_check(%h): got %b, want 0", d, parity_check);
    end
    parity_error = 1;
    tick();
    parity_error = 0;
    checks++;
    if (frame_done !== 1'b1 || rx_valid !== 1'b0 ||
        rx_data !== last_data || status !== 4'b0010) begin
      errors++;
      $display("FAIL perr_frame: got fd=%b v=%b data=%h st=%b, want 1 0 %h 0010",
               frame_done, rx_valid, rx_data, status, last_data);
    end
    clr_status = 1; parity_error = 1;
    tick();
    clr_status = 0; parity_error = 0;
    checks++;
    if (status !== 4'b0010) begin
      errors++;
      $display("FAIL set_beats_clr: got %b, want 0010", status);
    end
    clr_status = 1;
    tick();
    clr_status = 0;
    checks++;
    if (status !== 4'b0000) begin
      errors++;
      $display("FAIL perr_clr: got %b, want 0000", status);
    end
  endtask

  task automatic test_break_and_flags();
    send_bits(9'h000, 9);
    checks++;
    if (RX_shift_reg_2_0 !== 1'b0) begin
      errors++;
      $display("FAIL brk_or: got %b, want 0", RX_shift_reg_2_0);
    end
    break_error = 1;
    tick();
    break_error = 0;
    checks++;
    if (status !== 4'b1000 || frame_done !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL brk_flag: got st=%b fd=%b v=%b, want 1000 1 0",
               status, frame_done, rx_valid);
    end
    overflow_error = 1;
    tick(); tick(); tick();
    overflow_error = 0;
    stop_error = 1;
    tick();
    stop_error = 0;
    tick();
    checks++;
    if (status !== 4'b1101) begin
      errors++;
      $display("FAIL sticky: got %b, want 1101", status);
    end
    clr_status = 1;
    tick();
    clr_status = 0;
    checks++;
    if (status !== 4'b0000) begin
      errors++;
      $display("FAIL brk_clr: got %b, want 0000", status);
    end
  endtask

  task automatic test_sample_count();
    int cnt;
    clr_sample_count = 1;
    tick();
    clr_sample_count = 0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 20) begin
        clr_sample_count = 1; inc_sample_count = 1;
        cnt = 0;
      end else begin
        clr_sample_count = 0; inc_sample_count = 1;
        cnt = (cnt + 1) % 16;
      end
      tick();
      checks++;
      if (sample_count_done1 !== (cnt == 7) ||
          sample_count_done2 !== (cnt == 15)) begin
        errors++;
        $display("FAIL sample_cnt step %0d: got d1=%b d2=%b, want %b %b",
                 k, sample_count_done1, sample_count_done2,
                 cnt == 7, cnt == 15);
      end
    end
    inc_sample_count = 0; clr_sample_count = 0;
  endtask

  task automatic test_bit_saturation();
    clr_bit_count = 1;
    tick();
    clr_bit_count = 0;
    for (int k = 1; k <= 12; k++) begin
      inc_bit_count = 1;
      tick();
      checks++;
      if (bit_count_done !== (k >= 9) || bcd2 !== (k >= 7)) begin
        errors++;
        $display("FAIL bit_sat k=%0d: got %b/%b, want %b/%b",
                 k, bit_count_done, bcd2, k >= 9, k >= 7);
      end
    end
    inc_bit_count = 1; clr_bit_count = 1;
    tick();
    inc_bit_count = 0; clr_bit_count = 0;
    checks++;
    if (bit_count_done !== 1'b0) begin
      errors++;
      $display("FAIL bit_clr_prio: got %b, want 0", bit_count_done);
    end
  endtask

  task automatic test_sync_latency();
    rxd = 1;
    tick(); tick();
    rxd = 0;
    tick();
    checks++;
    if (serial_data_in !== 1'b1) begin
      errors++;
      $display("FAIL sync_lat1: got %b, want 1", serial_data_in);
    end
    rxd = 1;
    tick();
    checks++;
    if (serial_data_in !== 1'b0) begin
      errors++;
      $display("FAIL sync_lat2: got %b, want 0", serial_data_in);
    end
    tick();
    checks++;
    if (serial_data_in !== 1'b1) begin
      errors++;
      $display("FAIL sync_lat3: got %b, want 1", serial_data_in);
    end
  endtask

  task automatic test_mid_reset();
    send_bits(9'h00F, 4);
    inc_sample_count = 1;
    tick(); tick(); tick();
    inc_sample_count = 0;
    checks++;
    if (RX_shift_reg_2_0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got or=%b, want 1", RX_shift_reg_2_0);
    end
    reset = 1; load_RX_shift_reg = 1;
    tick();
    reset = 0; load_RX_shift_reg = 0;
    checks++;
    if (RX_shift_reg_2_0 !== 1'b0 || rx_valid !== 1'b0 ||
        rx_data !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got or=%b v=%b data=%h fd=%b, want 0 0 00 0",
               RX_shift_reg_2_0, rx_valid, rx_data, frame_done);
    end
    last_data = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      inc_bit_count = 1; inc_sample_count = 1;
      tick();
      checks++;
      if (bit_count_done !== (k == 9) || sample_count_done1 !== (k == 7)) begin
        errors++;
        $display("FAIL mid_cnt k=%0d: got bcd=%b d1=%b, want %b %b",
                 k, bit_count_done, sample_count_done1, k == 9, k == 7);
      end
    end
    inc_bit_count = 0; inc_sample_count = 0;
  endtask

  task automatic test_no_parity(input logic [6:0] d);
    send_bits({2'b00, d}, 6);
    checks++;
    if (bcd2 !== 1'b0) begin
      errors++;
      $display("FAIL np_early: got %b, want 0", bcd2);
    end
    shift_bit(d[6]);
    checks++;
    if (bcd2 !== 1'b1 || pchk2 !== 1'b1) begin
      errors++;
      $display("FAIL np_done(%h): got bcd=%b pchk=%b, want 1 1", d, bcd2, pchk2);
    end
    load_RX_shift_reg = 1;
    tick();
    load_RX_shift_reg = 0;
    checks++;
    if (rx_data2 !== d || rx_valid2 !== 1'b1) begin
      errors++;
      $display("FAIL np_load: got data=%h v=%b, want %h 1", rx_data2, rx_valid2, d);
    end
    last_data = rx_data;
    tick();
  endtask

  initial begin
    test_reset();
    test_good_frame(8'hA5);
    for (int i = 0; i < 4; i++) test_good_frame(8'($urandom_range(0, 255)));
    test_parity_error(8'hA5);
    test_parity_error(8'($urandom_range(0, 255)));
    test_break_and_flags();
    test_sample_count();
    test_bit_saturation();
    test_sync_latency();
    test_mid_reset();
    for (int i = 0; i < 3; i++) test_no_parity(7'($urandom_range(0, 127)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
